uart_receiver: RTL and testbench

Parametrised UART receiver: next generation of the fixed 8-bit `recieve` block. Adds configurable data width, parity, stop bits and baud divisor, 3-sample majority voting, false-start rejection, parity/framing error flags and a one-word holding register with read handshake and overrun detection. Sits between the `rxd` pin and the controller's register/FIFO logic.

---
 rtl/uart_receiver.sv | 137 +++++++++++++
 tb/tb_uart_receiver.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: parametrised UART receiver with 3-sample majority voting, error flags and a one-word holding register
module uart_receiver #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 read,
    output logic [DATA_BITS-1:0] word,
    output logic                 recieve_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] C_LO  = CW'(H - 1);
    localparam logic [CW-1:0] C_MID = CW'(H);
    localparam logic [CW-1:0] C_DEC = CW'(H + 1);
    localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    I_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    I_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD    = (PARITY == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic [1:0]            primed_q, primed_d;
    logic                  armed_q, armed_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [1:0]            smp_q, smp_d;
    logic [DATA_BITS-1:0]  sr_q, sr_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_BITS-1:0]  word_q, word_d;
    logic                  ready_q, ready_d;
    logic                  pe_q, pe_d;
    logic                  fe_q, fe_d;
    logic                  ovr_q, ovr_d;
    logic                  rxs, maj, dec, last, start, done;

    assign rxs   = sync_q[1];
    assign maj   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    assign dec   = cnt_q == C_DEC;
    assign last  = cnt_q == C_END;
    assign start = state_q == IDLE && armed_q && !rxs;

    // FSM state register; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: false start and last stop bit both return early at the decision point
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? START : IDLE;
            START:   state_d = (dec && maj) ? IDLE : last ? DATA : START;
            DATA:    state_d = (last && idx_q == I_DATA) ? ((PARITY != 0) ? PAR : STOP) : DATA;
            PAR:     state_d = last ? STOP : PAR;
            STOP:    state_d = (dec && idx_q == I_STOP) ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy covers the start-detect cycle, done marks the last stop decision
    always_comb begin
        busy = state_q != IDLE || start;
        done = state_q == STOP && dec && idx_q == I_STOP;
    end

    // Datapath next values: sampling, shifting, error tracking and the holding register handshake
    always_comb begin
        sync_d   = {sync_q[0], rxd};
        primed_d = {primed_q[0], 1'b1};
        armed_d  = (state_d != IDLE) ? armed_q : (state_q == IDLE) ? (armed_q | (rxs & primed_q[1])) : rxs;
        cnt_d    = (state_d == IDLE || last) ? '0 : cnt_q + CW'(1);
        idx_d    = (state_d != state_q) ? 4'd0 : last ? idx_q + 4'd1 : idx_q;
        smp_d    = (cnt_q == C_LO) ? {smp_q[1], rxs} : (cnt_q == C_MID) ? {rxs, smp_q[0]} : smp_q;
        sr_d     = (state_q == DATA && dec) ? {maj, sr_q[DATA_BITS-1:1]} : sr_q;
        perr_d   = start ? 1'b0 : (state_q == PAR && dec) ? (maj != (^sr_q ^ ODD)) : perr_q;
        ferr_d   = start ? 1'b0 : (state_q == STOP && dec && !maj) ? 1'b1 : ferr_q;
        word_d   = done ? sr_q : word_q;
        pe_d     = done ? perr_q : pe_q;
        fe_d     = done ? ferr_d : fe_q;
        ready_d  = done | (ready_q & ~read);
        ovr_d    = (done & ready_q & ~read) | (ovr_q & ~(read & ready_q));
    end

    // Datapath registers; the synchroniser idles high and arming waits until it has seen the real line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= 2'b11;
            primed_q <= 2'b00;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= 4'd0;
            smp_q    <= 2'b11;
            sr_q     <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            word_q   <= '0;
            ready_q  <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            primed_q <= primed_d;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            smp_q    <= smp_d;
            sr_q     <= sr_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            word_q   <= word_d;
            ready_q  <= ready_d;
            pe_q     <= pe_d;
            fe_q     <= fe_d;
            ovr_q    <= ovr_d;
        end
    end

    assign word          = word_q;
    assign recieve_ready = ready_q;
    assign parity_err    = pe_q;
    assign frame_err     = fe_q;
    assign overrun       = ovr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench over four receiver configurations (8N1, 8E1, 8O1, 5N2)
module tb_uart_receiver;
    typedef struct {
        logic [8:0] w;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] rxd = 4'hf;
    logic [3:0] rd  = 4'h0;
    logic [3:0] rdy, pe, fe, ov, bz;
    logic [7:0] w0, w1, w2;
    logic [4:0] w3;
    logic [8:0] wv [4];

    int cpb_a [4] = '{16, 16, 16, 8};
    int nb_a  [4] = '{8, 8, 8, 5};
    int par_a [4] = '{0, 1, 2, 0};
    int st_a  [4] = '{1, 1, 1, 2};

    exp_t sb [$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_receiver #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .rxd(rxd[0]), .read(rd[0]), .word(w0), .recieve_ready(rdy[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bz[0]));
    uart_receiver #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .rxd(rxd[1]), .read(rd[1]), .word(w1), .recieve_ready(rdy[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bz[1]));
    uart_receiver #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .rxd(rxd[2]), .read(rd[2]), .word(w2), .recieve_ready(rdy[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(bz[2]));
    uart_receiver #(.DATA_BITS(5), .CLKS_PER_BIT(8), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .rxd(rxd[3]), .read(rd[3]), .word(w3), .recieve_ready(rdy[3]),
        .parity_err(pe[3]), .frame_err(fe[3]), .overrun(ov[3]), .busy(bz[3]));

    assign wv[0] = {1'b0, w0};
    assign wv[1] = {1'b0, w1};
    assign wv[2] = {1'b0, w2};
    assign wv[3] = {4'b0, w3};

    // Drive one frame on line i starting at a negedge; expected result is queued first.
    task automatic send(input int i, input logic [8:0] d, input logic pbit, input logic stop0,
                        input int spike, input int hold);
        logic [15:0] fb;
        int          n;
        exp_t        e;
        fb  = '1;
        n   = 0;
        e.w = '0;
        fb[n] = 1'b0;
        n++;
        for (int k = 0; k < nb_a[i]; k++) begin
            fb[n]  = d[k];
            e.w[k] = d[k];
            n++;
        end
        if (par_a[i] != 0) begin
            fb[n] = pbit;
            n++;
        end
        for (int k = 0; k < st_a[i]; k++) begin
            fb[n] = !stop0;
            n++;
        end
        e.pe = (par_a[i] != 0) && (pbit != ((^e.w) ^ (par_a[i] == 2)));
        e.fe = stop0;
        sb.push_back(e);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < cpb_a[i]; j++) begin
                rxd[i] = fb[k] ^ (k == spike && j == cpb_a[i] / 2);
                @(negedge clk);
            end
        if (stop0) begin
            repeat (hold) @(negedge clk);
            rxd[i] = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic do_read(input int i);
        rd[i] = 1'b1;
        @(negedge clk);
        rd[i] = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        for (int i = 0; i < 4; i++) begin
            obs = {wv[i], rdy[i], pe[i], fe[i], ov[i], bz[i]};
            n_vec++;
            if (obs !== 14'h0) begin
                n_err++;
                $display("FAIL reset[%0d]: got %h want 0", i, obs);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int   c;
        exp_t e;
        c = 0;
        fork
            send(0, 9'h0a5, 1'b0, 1'b0, -1, 0);
            begin
                while (rdy[0] !== 1'b1 && c < 400) begin
                    @(posedge clk);
                    #1;
                    c++;
                end
            end
        join
        n_vec++;
        if (c != 9 * 16 + 8 + 2 + 2) begin
            n_err++;
            $display("FAIL basic_latency: got %0d want %0d", c, 9 * 16 + 8 + 2 + 2);
        end
        e = sb.pop_front();
        n_vec++;
        if ({rdy[0], wv[0], pe[0], fe[0], ov[0], bz[0]} !== {1'b1, e.w, e.pe, e.fe, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL basic_word: got rdy=%b w=%h pe=%b fe=%b ov=%b bz=%b want w=%h", rdy[0], wv[0], pe[0], fe[0], ov[0], bz[0], e.w);
        end
        n_vec++;
        if (wv[0] !== 9'h0a5) begin
            n_err++;
            $display("FAIL basic_const: got %h want a5", wv[0]);
        end
        do_read(0);
        n_vec++;
        if (rdy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL basic_read: rdy got %b want 0", rdy[0]);
        end
    endtask

    task automatic test_parity();
        int   inst [4] = '{1, 1, 2, 2};
        logic pb   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic want [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_t e;
        for (int t = 0; t < 4; t++) begin
            send(inst[t], 9'h007, pb[t], 1'b0, -1, 0);
            e = sb.pop_front();
            n_vec++;
            if ({rdy[inst[t]], wv[inst[t]], pe[inst[t]], fe[inst[t]]} !== {1'b1, e.w, e.pe, e.fe}) begin
                n_err++;
                $display("FAIL parity_sb[%0d]: got rdy=%b w=%h pe=%b fe=%b want w=%h pe=%b", t, rdy[inst[t]], wv[inst[t]], pe[inst[t]], fe[inst[t]], e.w, e.pe);
            end
            n_vec++;
            if (pe[inst[t]] !== want[t]) begin
                n_err++;
                $display("FAIL parity_const[%0d]: got %b want %b", t, pe[inst[t]], want[t]);
            end
            do_read(inst[t]);
        end
    endtask

    task automatic test_glitch();
        logic saw;
        saw = 1'b0;
        rxd[0] = 1'b0;
        repeat (2) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (40) begin
            @(negedge clk);
            saw = saw | bz[0];
        end
        n_vec++;
        if (saw !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_busy_pulse: got %b want 1", saw);
        end
        n_vec++;
        if ({rdy[0], bz[0]} !== 2'b00 || sb.size() != 0) begin
            n_err++;
            $display("FAIL glitch_idle: rdy=%b busy=%b want 0 0", rdy[0], bz[0]);
        end
    endtask

    task automatic test_overrun();
        exp_t e;
        send(0, 9'h011, 1'b0, 1'b0, -1, 0);
        send(0, 9'h022, 1'b0, 1'b0, -1, 0);
        e = sb.pop_front();
        e = sb.pop_front();
        n_vec++;
        if ({rdy[0], wv[0], ov[0]} !== {1'b1, e.w, 1'b1}) begin
            n_err++;
            $display("FAIL overrun_set: got rdy=%b w=%h ov=%b want 1 %h 1", rdy[0], wv[0], ov[0], e.w);
        end
        do_read(0);
        n_vec++;
        if ({rdy[0], ov[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL overrun_clear: got rdy=%b ov=%b want 0 0", rdy[0], ov[0]);
        end
        send(0, 9'h011, 1'b0, 1'b0, -1, 0);
        fork
            send(0, 9'h022, 1'b0, 1'b0, -1, 0);
            begin
                repeat (155) @(posedge clk);
                @(negedge clk);
                rd[0] = 1'b1;
                @(negedge clk);
                rd[0] = 1'b0;
            end
        join
        e = sb.pop_front();
        e = sb.pop_front();
        n_vec++;
        if ({rdy[0], wv[0], ov[0]} !== {1'b1, e.w, 1'b0}) begin
            n_err++;
            $display("FAIL overrun_coincident_read: got rdy=%b w=%h ov=%b want 1 %h 0", rdy[0], wv[0], ov[0], e.w);
        end
        do_read(0);
    endtask

    task automatic test_frame_err();
        exp_t e;
        send(0, 9'h03c, 1'b0, 1'b1, -1, 0);
        e = sb.pop_front();
        n_vec++;
        if ({rdy[0], wv[0], pe[0], fe[0]} !== {1'b1, e.w, e.pe, 1'b1}) begin
            n_err++;
            $display("FAIL frame_err: got rdy=%b w=%h pe=%b fe=%b want 1 %h 0 1", rdy[0], wv[0], pe[0], fe[0], e.w);
        end
        do_read(0);
        send(0, 9'h03c, 1'b0, 1'b0, 3, 0);
        e = sb.pop_front();
        n_vec++;
        if ({rdy[0], wv[0], fe[0]} !== {1'b1, e.w, 1'b0}) begin
            n_err++;
            $display("FAIL spike_vote: got rdy=%b w=%h fe=%b want 1 %h 0", rdy[0], wv[0], fe[0], e.w);
        end
        do_read(0);
        send(0, 9'h000, 1'b0, 1'b1, -1, 60);
        e = sb.pop_front();
        n_vec++;
        if ({rdy[0], wv[0], fe[0]} !== {1'b1, e.w, 1'b1}) begin
            n_err++;
            $display("FAIL break: got rdy=%b w=%h fe=%b want 1 %h 1", rdy[0], wv[0], fe[0], e.w);
        end
        do_read(0);
        repeat (200) @(negedge clk);
        n_vec++;
        if (rdy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL break_no_restart: rdy got %b want 0", rdy[0]);
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        rxd[0] = 1'b0;
        repeat (40) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (bz[0] !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_busy: got %b want 0", bz[0]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (250) @(negedge clk);
        n_vec++;
        if ({rdy[0], bz[0], wv[0]} !== 11'h0) begin
            n_err++;
            $display("FAIL low_through_reset: got rdy=%b busy=%b w=%h want 0 0 0", rdy[0], bz[0], wv[0]);
        end
        rxd[0] = 1'b1;
        repeat (4) @(negedge clk);
        send(0, 9'h096, 1'b0, 1'b0, -1, 0);
        e = sb.pop_front();
        n_vec++;
        if ({rdy[0], wv[0], fe[0]} !== {1'b1, e.w, 1'b0}) begin
            n_err++;
            $display("FAIL after_reset_frame: got rdy=%b w=%h fe=%b want 1 %h 0", rdy[0], wv[0], fe[0], e.w);
        end
        do_read(0);
    endtask

    task automatic test_sweep();
        logic [8:0] v [7];
        exp_t       e;
        v = '{9'h00, 9'h1f, 9'h0a, 9'h15, 9'h00, 9'h00, 9'h00};
        for (int k = 4; k < 7; k++) v[k] = 9'($urandom_range(0, 31));
        for (int k = 0; k < 7; k++) begin
            send(3, v[k], 1'b0, 1'b0, -1, 0);
            e = sb.pop_front();
            n_vec++;
            if ({rdy[3], wv[3], pe[3], fe[3]} !== {1'b1, e.w, e.pe, e.fe}) begin
                n_err++;
                $display("FAIL sweep5n2[%0d]: got rdy=%b w=%h fe=%b want w=%h", k, rdy[3], wv[3], fe[3], e.w);
            end
            do_read(3);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] v [3] = '{9'h05a, 9'h0c3, 9'h00f};
        fork
            for (int k = 0; k < 3; k++) send(0, v[k], 1'b0, 1'b0, -1, 0);
            for (int k = 0; k < 3; k++) begin
                int   c;
                exp_t e;
                c = 0;
                while (rdy[0] !== 1'b1 && c < 400) begin
                    @(negedge clk);
                    c++;
                end
                e = sb.pop_front();
                n_vec++;
                if ({rdy[0], wv[0], ov[0], fe[0]} !== {1'b1, e.w, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL back_to_back[%0d]: got rdy=%b w=%h ov=%b fe=%b want 1 %h 0 0", k, rdy[0], wv[0], ov[0], fe[0], e.w);
                end
                do_read(0);
            end
        join
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_overrun();
        test_frame_err();
        test_reset_midframe();
        test_sweep();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
